// File: rtl/connector_pkg.sv
// Connector-side trace field widths and the packet/block containers used by
// the ingress serializer.
package connector_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned IRETIRE_LEN = 7;
    localparam int unsigned ITYPE_LEN   = 3;
    localparam int unsigned PRIV_LEN    = 2;
    localparam int unsigned TE_N        = 2;

    // One connector beat: per-lane fields, shared exception info, lane mask.
    typedef struct packed {
        logic [TE_N-1:0]                  mask;
        logic [TE_N-1:0][IRETIRE_LEN-1:0] iretire;
        logic [TE_N-1:0]                  ilastsize;
        logic [TE_N-1:0][ITYPE_LEN-1:0]   itype;
        logic [XLEN-1:0]                  cause;
        logic [XLEN-1:0]                  tval;
        logic [PRIV_LEN-1:0]              priv;
        logic [TE_N-1:0][XLEN-1:0]        iaddr;
    } te_packet_t;

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [XLEN-1:0]        cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
        logic [XLEN-1:0]        iaddr;
    } te_block_t;

endpackage

// File: rtl/te_ingress_serializer_pkg.sv
// Serializer FSM encoding and lane-selection helper.
package te_ingress_serializer_pkg;
    import connector_pkg::*;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_EMIT  = 1'b1;

    localparam int unsigned LANE_W = (TE_N > 1) ? $clog2(TE_N) : 1;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [LANE_W-1:0] first_lane(input logic [TE_N-1:0] m);
        first_lane = '0;
        for (int i = TE_N - 1; i >= 0; i--) begin
            if (m[i]) begin
                first_lane = i[LANE_W-1:0];
            end
        end
    endfunction

endpackage

// File: rtl/te_ingress_serializer_if.sv
// Encoder-side handshake: one serialized block per valid/ready transfer.
interface te_ingress_serializer_if;
    import connector_pkg::*;

    logic                   valid_o;
    logic                   ready_i;
    logic [IRETIRE_LEN-1:0] iretire_o;
    logic                   ilastsize_o;
    logic [ITYPE_LEN-1:0]   itype_o;
    logic [XLEN-1:0]        cause_o;
    logic [XLEN-1:0]        tval_o;
    logic [PRIV_LEN-1:0]    priv_o;
    logic [XLEN-1:0]        iaddr_o;

    modport master (
        output valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
        input  ready_i
    );

    modport slave (
        input  valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
        output ready_i
    );

endinterface

// File: rtl/te_packet_fifo.sv
// Generic DEPTH-entry FIFO; head entry is readable combinationally.
module te_packet_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  T                         wdata,
    input  logic                     pop,
    output T                         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    T                mem_r [DEPTH];
    logic [AW-1:0]   wptr_r;
    logic [AW-1:0]   rptr_r;
    logic [AW:0]     count_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign rdata     = mem_r[rptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/te_ingress_serializer.sv
// Buffers N-lane connector packets and replays their valid lanes one block
// per cycle to the encoder, with a sticky flag for dropped packets.
module te_ingress_serializer
    import connector_pkg::*;
    import te_ingress_serializer_pkg::*;
#(
    parameter int unsigned N     = TE_N,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N-1:0]             valid_i,
    input  logic [N*IRETIRE_LEN-1:0] iretire_i,
    input  logic [N-1:0]             ilastsize_i,
    input  logic [N*ITYPE_LEN-1:0]   itype_i,
    input  logic [XLEN-1:0]          cause_i,
    input  logic [XLEN-1:0]          tval_i,
    input  logic [PRIV_LEN-1:0]      priv_i,
    input  logic [N*XLEN-1:0]        iaddr_i,
    te_ingress_serializer_if.master  enc,
    output logic                     overflow_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    te_packet_t       wr_pkt_s;
    te_packet_t       head_s;
    logic             push_s, pop_s, full_s, empty_s;
    logic [CW-1:0]    count_s;
    logic [N-1:0]     done_r, rem_s, sel_s;
    logic [LANE_W-1:0] idx_s;
    logic             valid_s, last_s, fire_s;
    logic [0:0]       state_r, state_nxt_s;
    logic             overflow_r;

    always_comb begin
        wr_pkt_s.mask      = valid_i;
        wr_pkt_s.iretire   = iretire_i;
        wr_pkt_s.ilastsize = ilastsize_i;
        wr_pkt_s.itype     = itype_i;
        wr_pkt_s.cause     = cause_i;
        wr_pkt_s.tval      = tval_i;
        wr_pkt_s.priv      = priv_i;
        wr_pkt_s.iaddr     = iaddr_i;
    end

    te_packet_fifo #(.T(te_packet_t), .DEPTH(DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push_s),
        .wdata  (wr_pkt_s),
        .pop    (pop_s),
        .rdata  (head_s),
        .full   (full_s),
        .empty  (empty_s),
        .count  (count_s)
    );

    // Lanes of the head still owed to the encoder and the one presented now.
    always_comb begin
        valid_s = (state_r == ST_EMIT) && !empty_s;
        if (valid_s) begin
            rem_s = head_s.mask & ~done_r;
        end else begin
            rem_s = '0;
        end
        idx_s        = first_lane(rem_s);
        sel_s        = '0;
        sel_s[idx_s] = 1'b1;
        last_s       = ((rem_s & ~sel_s) == '0);
        fire_s       = valid_s && enc.ready_i;
        pop_s        = fire_s && last_s;
        push_s       = (|valid_i) && (!full_s || pop_s);
    end

    // Served-lane tracking for the head packet, cleared when it pops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_r <= '0;
        end else if (pop_s) begin
            done_r <= '0;
        end else if (fire_s) begin
            done_r <= done_r | sel_s;
        end else begin
            done_r <= done_r;
        end
    end

    always_comb begin
        case (state_r)
            ST_EMPTY: begin
                if (push_s) begin
                    state_nxt_s = ST_EMIT;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_EMIT: begin
                if (pop_s && (count_s == CW'(1'b1)) && !push_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // State register plus the sticky drop flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_EMPTY;
            overflow_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((|valid_i) && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Presented block: packet-wide fields replicated onto every lane.
    always_comb begin
        enc.valid_o = valid_s;
        if (valid_s) begin
            enc.iretire_o   = head_s.iretire[idx_s];
            enc.ilastsize_o = head_s.ilastsize[idx_s];
            enc.itype_o     = head_s.itype[idx_s];
            enc.cause_o     = head_s.cause;
            enc.tval_o      = head_s.tval;
            enc.priv_o      = head_s.priv;
            enc.iaddr_o     = head_s.iaddr[idx_s];
        end else begin
            enc.iretire_o   = '0;
            enc.ilastsize_o = 1'b0;
            enc.itype_o     = '0;
            enc.cause_o     = '0;
            enc.tval_o      = '0;
            enc.priv_o      = '0;
            enc.iaddr_o     = '0;
        end
    end

    assign overflow_o = overflow_r;

endmodule
